// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR engine: one tap per cycle through an external combinational
// multiplier, accumulates, saturates to DW bits and presents the result via valid/ready.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | stepping taps k = 0..NTAPS-1, accumulating products
// OUT   | holding saturated result until downstream accepts it
module fir_tap_sequencer #(
   parameter int NTAPS = 8,
   parameter int DW    = 16,
   parameter int ACC_W = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DW-1:0]     in_sample,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic signed [DW-1:0]     coef_data,
   output logic signed [DW-1:0]     mult_a,
   output logic signed [DW-1:0]     mult_b,
   input  logic signed [DW-1:0]     mult_c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DW-1:0]     out_sample,
   output logic                     busy
);

   localparam int AW = $clog2(NTAPS);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
   localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                  state;
   logic [AW-1:0]           k;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [DW-1:0]    sat_val;
   logic signed [DW-1:0]    delay [NTAPS];
   logic signed [DW-1:0]    coef  [NTAPS];

   // Newest sample pairs with coef[0]; index wraps naturally in AW bits.
   assign rd_idx = wr_ptr - k;

   assign mult_a    = (state == MAC) ? delay[rd_idx] : '0;
   assign mult_b    = (state == MAC) ? coef[k]       : '0;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);

   always_comb begin
      acc_next = ((k == '0) ? '0 : acc) + {{(ACC_W - DW){mult_c[DW-1]}}, mult_c};
      if (acc_next > SAT_HI)
         sat_val = SAT_HI[DW-1:0];
      else if (acc_next < SAT_LO)
         sat_val = SAT_LO[DW-1:0];
      else
         sat_val = acc_next[DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         wr_ptr     <= '0;
         acc        <= '0;
         out_sample <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            delay[i] <= '0;
            coef[i]  <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (coef_we)
                  coef[coef_addr] <= coef_data;
               if (in_valid) begin
                  delay[wr_ptr + 1'b1] <= in_sample;
                  wr_ptr               <= wr_ptr + 1'b1;
                  k                    <= '0;
                  state                <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               k   <= k + 1'b1;
               if (k == K_LAST) begin
                  out_sample <= sat_val;
                  state      <= OUT;
               end
            end
            OUT: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
